gmux_quad_seq: RTL and testbench

- Sequencer that drives the SSEL and per-quadrant SEN/DEN/DYNEN/VLP controls of a global high-speed clock mux.
- Accepts mode-change requests over a valid/ready handshake and applies them glitch-free: gate affected quadrants, settle, switch source/mode, settle, ungate.
- Sits in the clock-management fabric between the configuration/power controller and the clock-mux primitive.

---
 rtl/gmux_quad_seq.sv | 158 +++++++++++++++
 tb/tb_gmux_quad_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmux_quad_seq.sv
// Sequencer for a global high-speed clock mux. It applies source and per-quadrant
// mode changes glitch-free: gate, settle, switch, settle, ungate.
module gmux_quad_seq #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_SSEL,
  input  logic [7:0] REQ_MODE,
  input  logic [3:0] DYN_GATE,
  output logic       SSEL,
  output logic [3:0] SEN,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP,
  output logic [7:0] CUR_MODE,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATE   = 2'd1,
    S_SWITCH = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [7:0] C_SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [1:0] M_STATIC = 2'b01;
  localparam logic [1:0] M_DYN    = 2'b10;
  localparam logic [1:0] M_VLP    = 2'b11;

  state_t     r_state, w_state_nxt;
  logic       r_ssel, w_ssel_nxt;
  logic [7:0] r_cur_mode, w_mode_nxt;
  logic       r_tgt_ssel, w_tgt_ssel_nxt;
  logic [7:0] r_tgt_mode, w_tgt_mode_nxt;
  logic [3:0] r_gate, w_gate_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_sen, r_den, r_dynen, r_vlp;
  logic [3:0] w_sen_nxt, w_den_nxt, w_dynen_nxt, w_vlp_nxt;
  logic [3:0] w_affected;
  logic       w_accept;
  logic       w_cnt_last;

  assign w_accept   = REQ_VALID && (r_state == S_IDLE);
  assign w_cnt_last = (r_cnt == 8'd1);

  // A source change disturbs every running quadrant; otherwise only the ones whose mode moves.
  always_comb begin
    w_affected = '0;
    for (int q = 0; q < 4; q++) begin
      if (REQ_SSEL != r_ssel)
        w_affected[q] = (r_cur_mode[2*q +: 2] != M_VLP);
      else
        w_affected[q] = (REQ_MODE[2*q +: 2] != r_cur_mode[2*q +: 2]);
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_ssel_nxt     = r_ssel;
    w_mode_nxt     = r_cur_mode;
    w_tgt_ssel_nxt = r_tgt_ssel;
    w_tgt_mode_nxt = r_tgt_mode;
    w_gate_nxt     = r_gate;
    w_cnt_nxt      = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tgt_ssel_nxt = REQ_SSEL;
          w_tgt_mode_nxt = REQ_MODE;
          w_gate_nxt     = w_affected;
          w_cnt_nxt      = C_SETTLE;
          w_state_nxt    = (w_affected == 4'd0) ? S_FIN : S_GATE;
        end
      end
      S_GATE: begin
        if (w_cnt_last) begin
          w_ssel_nxt  = r_tgt_ssel;
          w_mode_nxt  = r_tgt_mode;
          w_cnt_nxt   = C_SETTLE;
          w_state_nxt = S_SWITCH;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_SWITCH: begin
        if (w_cnt_last) begin
          w_gate_nxt  = '0;
          w_state_nxt = S_FIN;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Mux controls are decoded from next-state values and registered, so they never glitch.
  always_comb begin
    w_sen_nxt   = '0;
    w_den_nxt   = '0;
    w_dynen_nxt = '0;
    w_vlp_nxt   = '0;
    for (int q = 0; q < 4; q++) begin
      w_sen_nxt[q]   = (w_mode_nxt[2*q +: 2] == M_STATIC) && !w_gate_nxt[q];
      w_den_nxt[q]   = (w_mode_nxt[2*q +: 2] == M_DYN) && !w_gate_nxt[q] && DYN_GATE[q];
      w_dynen_nxt[q] = (w_mode_nxt[2*q +: 2] == M_DYN);
      w_vlp_nxt[q]   = (w_mode_nxt[2*q +: 2] == M_VLP);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_ssel     <= 1'b1;
      r_cur_mode <= 8'h55;
      r_tgt_ssel <= 1'b1;
      r_tgt_mode <= 8'h55;
      r_gate     <= '0;
      r_cnt      <= '0;
      r_sen      <= 4'hF;
      r_den      <= '0;
      r_dynen    <= '0;
      r_vlp      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ssel     <= w_ssel_nxt;
      r_cur_mode <= w_mode_nxt;
      r_tgt_ssel <= w_tgt_ssel_nxt;
      r_tgt_mode <= w_tgt_mode_nxt;
      r_gate     <= w_gate_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sen      <= w_sen_nxt;
      r_den      <= w_den_nxt;
      r_dynen    <= w_dynen_nxt;
      r_vlp      <= w_vlp_nxt;
    end
  end

  assign SSEL      = r_ssel;
  assign CUR_MODE  = r_cur_mode;
  assign SEN       = r_sen;
  assign DEN       = r_den;
  assign DYNEN     = r_dynen;
  assign VLP       = r_vlp;
  assign REQ_READY = (r_state == S_IDLE);
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FIN);

endmodule

// File: tb/tb_gmux_quad_seq.sv
// Bench for gmux_quad_seq: two instances (settle 4 and settle 2) checked every cycle
// against a timeline model, plus directed literal expectations.
module tb_gmux_quad_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       req_valid [2];
  logic       REQ_SSEL;
  logic [7:0] REQ_MODE;
  logic [3:0] DYN_GATE;

  logic       rdy [2], ssel [2], busy [2], done [2];
  logic [3:0] sen [2], den [2], dynen [2], vlp [2];
  logic [7:0] cur [2];

  gmux_quad_seq #(.SETTLE_CYCLES(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid[0]), .REQ_READY(rdy[0]),
    .REQ_SSEL(REQ_SSEL), .REQ_MODE(REQ_MODE), .DYN_GATE(DYN_GATE),
    .SSEL(ssel[0]), .SEN(sen[0]), .DEN(den[0]), .DYNEN(dynen[0]), .VLP(vlp[0]),
    .CUR_MODE(cur[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  gmux_quad_seq #(.SETTLE_CYCLES(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .REQ_VALID(req_valid[1]), .REQ_READY(rdy[1]),
    .REQ_SSEL(REQ_SSEL), .REQ_MODE(REQ_MODE), .DYN_GATE(DYN_GATE),
    .SSEL(ssel[1]), .SEN(sen[1]), .DEN(den[1]), .DYNEN(dynen[1]), .VLP(vlp[1]),
    .CUR_MODE(cur[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: a request is a timeline measured in edges since acceptance.
  logic       m_ssel  [2];
  logic [1:0] m_mode  [2][4];
  logic       m_busy  [2];
  int         m_t     [2];
  logic       m_empty [2];
  logic [3:0] m_aff   [2];
  logic       m_tssel [2];
  logic [1:0] m_tmode [2][4];
  logic [3:0] m_dynq  [2];

  function automatic int s_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic model_step(input int d);
    int s;
    s = s_of(d);
    if (RST) begin
      m_ssel[d]  = 1'b1;
      for (int q = 0; q < 4; q++) m_mode[d][q] = 2'b01;
      m_busy[d]  = 1'b0;
      m_t[d]     = 0;
      m_empty[d] = 1'b0;
      m_aff[d]   = 4'd0;
      m_dynq[d]  = 4'd0;
    end else begin
      m_dynq[d] = DYN_GATE;
      if (!m_busy[d]) begin
        if (req_valid[d]) begin
          m_tssel[d] = REQ_SSEL;
          for (int q = 0; q < 4; q++) m_tmode[d][q] = REQ_MODE[2*q +: 2];
          for (int q = 0; q < 4; q++)
            m_aff[d][q] = (REQ_SSEL != m_ssel[d]) ? (m_mode[d][q] != 2'b11)
                                                   : (m_tmode[d][q] != m_mode[d][q]);
          m_empty[d] = (m_aff[d] == 4'd0);
          m_busy[d]  = 1'b1;
          m_t[d]     = 0;
        end
      end else begin
        m_t[d]++;
        if (m_empty[d]) begin
          if (m_t[d] == 1) m_busy[d] = 1'b0;
        end else begin
          if (m_t[d] == s) begin
            m_ssel[d] = m_tssel[d];
            for (int q = 0; q < 4; q++) m_mode[d][q] = m_tmode[d][q];
          end
          if (m_t[d] == 2*s + 1) m_busy[d] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  function automatic logic [27:0] exp_vec(input int d);
    logic [3:0] g, se, de, dy, vl;
    logic [7:0] cm;
    logic       dn;
    int         s;
    s = s_of(d);
    for (int q = 0; q < 4; q++) begin
      g[q]  = m_busy[d] && !m_empty[d] && m_aff[d][q] && (m_t[d] < 2*s);
      se[q] = (m_mode[d][q] == 2'b01) && !g[q];
      dy[q] = (m_mode[d][q] == 2'b10);
      vl[q] = (m_mode[d][q] == 2'b11);
      de[q] = dy[q] && !g[q] && m_dynq[d][q];
      cm[2*q +: 2] = m_mode[d][q];
    end
    dn = m_busy[d] && (m_empty[d] ? (m_t[d] == 0) : (m_t[d] == 2*s));
    return {!m_busy[d], m_busy[d], dn, m_ssel[d], se, de, dy, vl, cm};
  endfunction

  function automatic logic [27:0] act_vec(input int d);
    return {rdy[d], busy[d], done[d], ssel[d], sen[d], den[d], dynen[d], vlp[d], cur[d]};
  endfunction

  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cycle_dut%0d", d), 32'(act_vec(d)), 32'(exp_vec(d)));
        check($sformatf("invariant_dut%0d", d),
              32'((vlp[d] & (sen[d] | den[d])) | (sen[d] & den[d])), 32'd0);
      end
    end
  end

  task automatic wait_done(input int d, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (done[d] === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    REQ_SSEL     = 1'b1;
    REQ_MODE     = 8'h55;
    DYN_GATE     = 4'hF;
    @(posedge CLK);
    cmp_en = 1'b1;

    // Reset values
    @(negedge CLK);
    check("rst_ssel",  32'(ssel[0]),  32'd1);
    check("rst_sen",   32'(sen[0]),   32'hF);
    check("rst_den",   32'(den[0]),   32'h0);
    check("rst_dynen", 32'(dynen[0]), 32'h0);
    check("rst_vlp",   32'(vlp[0]),   32'h0);
    check("rst_cur",   32'(cur[0]),   32'h55);
    check("rst_ready", 32'(rdy[0]),   32'd1);
    check("rst_done",  32'(done[0]),  32'd0);
    check("rst_sen2",  32'(sen[1]),   32'hF);
    RST = 1'b0;

    // TL STATIC -> DYNAMIC, settle 4
    @(negedge CLK);
    REQ_SSEL = 1'b1; REQ_MODE = 8'h56; req_valid[0] = 1'b1;
    @(negedge CLK);
    req_valid[0] = 1'b0;
    check("t2_sen_k0",  32'(sen[0]),  32'hE);
    check("t2_busy_k0", 32'(busy[0]), 32'd1);
    check("t2_rdy_k0",  32'(rdy[0]),  32'd0);
    repeat (3) @(negedge CLK);
    check("t2_dynen_k3", 32'(dynen[0]), 32'h0);
    @(negedge CLK);
    check("t2_dynen_k4", 32'(dynen[0]), 32'h1);
    check("t2_cur_k4",   32'(cur[0]),   32'h56);
    check("t2_den_k4",   32'(den[0]),   32'h0);
    repeat (3) @(negedge CLK);
    check("t2_done_k7", 32'(done[0]), 32'd0);
    check("t2_den_k7",  32'(den[0]),  32'h0);
    @(negedge CLK);
    check("t2_done_k8", 32'(done[0]), 32'd1);
    check("t2_den_k8",  32'(den[0]),  32'h1);
    check("t2_sen_k8",  32'(sen[0]),  32'hE);
    @(negedge CLK);
    check("t2_done_k9", 32'(done[0]), 32'd0);
    check("t2_rdy_k9",  32'(rdy[0]),  32'd1);
    DYN_GATE = 4'hE;
    @(negedge CLK);
    check("t2_den_track0", 32'(den[0]), 32'h0);
    DYN_GATE = 4'hF;
    @(negedge CLK);
    check("t2_den_track1", 32'(den[0]), 32'h1);

    // SSEL 1 -> 0 with modes unchanged, settle 2
    REQ_SSEL = 1'b0; REQ_MODE = 8'h55; req_valid[1] = 1'b1;
    @(negedge CLK);
    req_valid[1] = 1'b0;
    check("t3_sen_k0",  32'(sen[1]),  32'h0);
    check("t3_ssel_k0", 32'(ssel[1]), 32'd1);
    @(negedge CLK);
    check("t3_ssel_k1", 32'(ssel[1]), 32'd1);
    @(negedge CLK);
    check("t3_ssel_k2", 32'(ssel[1]), 32'd0);
    check("t3_sen_k2",  32'(sen[1]),  32'h0);
    @(negedge CLK);
    check("t3_sen_k3",  32'(sen[1]),  32'h0);
    check("t3_done_k3", 32'(done[1]), 32'd0);
    @(negedge CLK);
    check("t3_sen_k4",  32'(sen[1]),  32'hF);
    check("t3_done_k4", 32'(done[1]), 32'd1);
    @(negedge CLK);
    check("t3_done_k5", 32'(done[1]), 32'd0);
    check("t3_rdy_k5",  32'(rdy[1]),  32'd1);

    // Request equal to current state
    REQ_SSEL = 1'b1; REQ_MODE = 8'h56; req_valid[0] = 1'b1;
    @(negedge CLK);
    req_valid[0] = 1'b0;
    check("t4_done_k0", 32'(done[0]), 32'd1);
    check("t4_rdy_k0",  32'(rdy[0]),  32'd0);
    check("t4_sen_k0",  32'(sen[0]),  32'hE);
    check("t4_cur_k0",  32'(cur[0]),  32'h56);
    @(negedge CLK);
    check("t4_done_k1", 32'(done[0]), 32'd0);
    check("t4_rdy_k1",  32'(rdy[0]),  32'd1);

    // BR STATIC -> VLP
    REQ_MODE = 8'hD6; req_valid[0] = 1'b1;
    @(negedge CLK);
    req_valid[0] = 1'b0;
    check("t5_sen_k0", 32'(sen[0]), 32'h6);
    check("t5_vlp_k0", 32'(vlp[0]), 32'h0);
    check("t5_den_k0", 32'(den[0]), 32'h1);
    repeat (3) @(negedge CLK);
    check("t5_vlp_k3", 32'(vlp[0]), 32'h0);
    @(negedge CLK);
    check("t5_vlp_k4", 32'(vlp[0]), 32'h8);
    check("t5_sen_k4", 32'(sen[0]), 32'h6);
    check("t5_cur_k4", 32'(cur[0]), 32'hD6);
    repeat (4) @(negedge CLK);
    check("t5_done_k8", 32'(done[0]), 32'd1);
    check("t5_sen_k8",  32'(sen[0]),  32'h6);
    @(negedge CLK);
    check("t5_sen_k9",  32'(sen[0]),  32'h6);
    check("t5_vlp_k9",  32'(vlp[0]),  32'h8);

    // Reset mid-sequence, then a held request
    REQ_MODE = 8'h56; req_valid[0] = 1'b1;
    @(negedge CLK);
    check("t6_busy_k0", 32'(busy[0]), 32'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t6_rst_ssel", 32'(ssel[0]), 32'd1);
    check("t6_rst_sen",  32'(sen[0]),  32'hF);
    check("t6_rst_cur",  32'(cur[0]),  32'h55);
    check("t6_rst_vlp",  32'(vlp[0]),  32'h0);
    check("t6_rst_busy", 32'(busy[0]), 32'd0);
    check("t6_rst_done", 32'(done[0]), 32'd0);
    @(negedge CLK);
    check("t6_busy_j0", 32'(busy[0]), 32'd1);
    check("t6_sen_j0",  32'(sen[0]),  32'hE);
    REQ_MODE = 8'h55;
    repeat (4) @(negedge CLK);
    check("t6_cur_j4",   32'(cur[0]),   32'h56);
    check("t6_dynen_j4", 32'(dynen[0]), 32'h1);
    repeat (4) @(negedge CLK);
    check("t6_done_j8", 32'(done[0]), 32'd1);
    check("t6_cur_j8",  32'(cur[0]),  32'h56);
    @(negedge CLK);
    check("t6_done_j9", 32'(done[0]), 32'd0);
    check("t6_rdy_j9",  32'(rdy[0]),  32'd1);
    @(negedge CLK);
    req_valid[0] = 1'b0;
    check("t6_busy_j10", 32'(busy[0]), 32'd1);
    check("t6_done_j10", 32'(done[0]), 32'd0);
    check("t6_den_j10",  32'(den[0]),  32'h0);
    wait_done(0, 40, "t6_second_done");
    check("t6_cur_final", 32'(cur[0]), 32'h55);
    @(negedge CLK);
    check("t6_sen_final", 32'(sen[0]), 32'hF);
    check("t6_rdy_final", 32'(rdy[0]), 32'd1);

    repeat (4) @(negedge CLK);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
